// File: rtl/pipeline_ctrl_350.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_350
//   Control side of the pipeline stage latches. Decodes the instructions held
//   in F/D and D/X and drives write enables plus bubble/flush selects for the
//   PC, F/D, D/X, X/M and M/W latches. Three hazards are handled:
//     - load-use: one-cycle stall of PC and F/D with a nop injected into D/X
//     - taken branch/jump: F/D flushed and D/X bubbled
//     - multi-cycle mult/div: front end frozen until md_ready, with a
//       MD_MAX_CYCLES watchdog that latches md_error (cleared only by reset)
//   A bubble or flush makes the receiving latch capture a nop (32'h0).
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   fd_ins, dx_ins          instructions currently in the F/D and D/X latches
//   branch_taken            X stage resolved a taken branch/jump this cycle
//   md_ready                mult/div result valid (single-cycle pulse)
//   pc/fd/dx/xm/mw_wren     latch write enables
//   fd_flush, dx_bubble,
//   xm_bubble               receiving latch captures a nop
//   md_busy                 waiting on the mult/div unit
//   md_error                sticky mult/div timeout
//   stall_count             cycles with pc_wren=0 (zero unless enabled)
//
// Configuration macro
//   PIPE_STALL_COUNT_EN     when defined, stall_count is a free-running
//                           32-bit counter of PC-stall cycles; otherwise
//                           stall_count is tied to zero.
//
// All control outputs are combinational from the FSM state and the inputs,
// and are forced to zero while reset_n is low.
// ---------------------------------------------------------------------------
module pipeline_ctrl_350 #(
  parameter int unsigned MD_MAX_CYCLES = 40,
  parameter int unsigned CNT_W         = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_ins,
  input  logic [31:0] dx_ins,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_wren,
  output logic        fd_wren,
  output logic        dx_wren,
  output logic        xm_wren,
  output logic        mw_wren,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        xm_bubble,
  output logic        md_busy,
  output logic        md_error,
  output logic [31:0] stall_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Counter value seen on the last permitted wait cycle.
  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MD_WAIT = 2'b01,
    ST_ERROR   = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use_s;
  logic dx_md_s;
  logic pc_wren_s, fd_wren_s, dx_wren_s, xm_wren_s, mw_wren_s;
  logic fd_flush_s, dx_bubble_s, xm_bubble_s, md_busy_s, md_error_s;

  // True when instruction ins reads register r as a source operand.
  // R-type reads rs and rt; every other format reads rs; sw/bne/blt also read rd.
  function automatic logic ins_reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [4:0] op;
    logic       hit;
    op  = ins[31:27];
    hit = (ins[21:17] == r);
    if (op == OP_RTYPE) begin
      hit = hit | (ins[16:12] == r);
    end else if ((op == OP_SW) || (op == OP_BNE) || (op == OP_BLT)) begin
      hit = hit | (ins[26:22] == r);
    end else begin
      hit = hit;
    end
    return hit;
  endfunction

  // Fields that never influence control; named so lint treats them as intentionally unused.
  logic unused_ins_bits_s;
  assign unused_ins_bits_s = ^{fd_ins[11:0], dx_ins[21:7], dx_ins[1:0]};

  // Hazard decode from the F/D and D/X instructions.
  always_comb begin
    load_use_s = (dx_ins[31:27] == OP_LW) && (dx_ins[26:22] != 5'd0) &&
                 ins_reads_reg(fd_ins, dx_ins[26:22]);
    dx_md_s    = (dx_ins[31:27] == OP_RTYPE) &&
                 ((dx_ins[6:2] == ALU_MUL) || (dx_ins[6:2] == ALU_DIV));
  end

  // Next-state, wait counter and raw control outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_wren_s   = 1'b1;
    fd_wren_s   = 1'b1;
    dx_wren_s   = 1'b1;
    xm_wren_s   = 1'b1;
    mw_wren_s   = 1'b1;
    fd_flush_s  = 1'b0;
    dx_bubble_s = 1'b0;
    xm_bubble_s = 1'b0;
    md_busy_s   = 1'b0;
    md_error_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        cnt_d = {CNT_W{1'b0}};
        if (branch_taken) begin
          fd_flush_s  = 1'b1;
          dx_bubble_s = 1'b1;
        end else if (load_use_s) begin
          // The injected nop reaches D/X next cycle, which clears the hazard.
          pc_wren_s   = 1'b0;
          fd_wren_s   = 1'b0;
          dx_bubble_s = 1'b1;
        end else if (dx_md_s) begin
          pc_wren_s   = 1'b0;
          fd_wren_s   = 1'b0;
          dx_wren_s   = 1'b0;
          xm_bubble_s = 1'b1;
          state_d     = ST_MD_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        // X holds the mult/div, so branch_taken cannot be meaningful here.
        md_busy_s   = 1'b1;
        pc_wren_s   = 1'b0;
        fd_wren_s   = 1'b0;
        dx_wren_s   = 1'b0;
        xm_bubble_s = 1'b1;
        if (md_ready) begin
          pc_wren_s   = 1'b1;
          fd_wren_s   = 1'b1;
          dx_wren_s   = 1'b1;
          xm_bubble_s = 1'b0;
          state_d     = ST_RUN;
          cnt_d       = {CNT_W{1'b0}};
        end else if (cnt_q == MD_LAST) begin
          state_d = ST_ERROR;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        pc_wren_s  = 1'b0;
        fd_wren_s  = 1'b0;
        dx_wren_s  = 1'b0;
        xm_wren_s  = 1'b0;
        mw_wren_s  = 1'b0;
        md_error_s = 1'b1;
      end
      default: begin
        // Unreachable encoding: freeze the pipe and report an error.
        pc_wren_s  = 1'b0;
        fd_wren_s  = 1'b0;
        dx_wren_s  = 1'b0;
        xm_wren_s  = 1'b0;
        mw_wren_s  = 1'b0;
        md_error_s = 1'b1;
        state_d    = ST_ERROR;
      end
    endcase
  end

  // FSM state and mult/div wait counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every control output is held low for the whole time reset_n is asserted.
  assign pc_wren   = reset_n & pc_wren_s;
  assign fd_wren   = reset_n & fd_wren_s;
  assign dx_wren   = reset_n & dx_wren_s;
  assign xm_wren   = reset_n & xm_wren_s;
  assign mw_wren   = reset_n & mw_wren_s;
  assign fd_flush  = reset_n & fd_flush_s;
  assign dx_bubble = reset_n & dx_bubble_s;
  assign xm_bubble = reset_n & xm_bubble_s;
  assign md_busy   = reset_n & md_busy_s;
  assign md_error  = reset_n & md_error_s;

`ifdef PIPE_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count PC-stall cycles; wraps naturally at 2^32.
  always_comb begin
    if (!pc_wren) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_350.sv
module tb_pipeline_ctrl_350;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] fd_ins;
  logic [31:0] dx_ins;
  logic        branch_taken;
  logic        md_ready;
  logic        pc_wren, fd_wren, dx_wren, xm_wren, mw_wren;
  logic        fd_flush, dx_bubble, xm_bubble, md_busy, md_error;
  logic [31:0] stall_count;

  int errors = 0;
  int checks = 0;

  pipeline_ctrl_350 dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fd_ins       (fd_ins),
    .dx_ins       (dx_ins),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .pc_wren      (pc_wren),
    .fd_wren      (fd_wren),
    .dx_wren      (dx_wren),
    .xm_wren      (xm_wren),
    .mw_wren      (mw_wren),
    .fd_flush     (fd_flush),
    .dx_bubble    (dx_bubble),
    .xm_bubble    (xm_bubble),
    .md_busy      (md_busy),
    .md_error     (md_error),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  // {pc,fd,dx,xm,mw wren, fd_flush, dx_bubble, xm_bubble, md_busy, md_error}
  logic [9:0] outs;
  assign outs = {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren,
                 fd_flush, dx_bubble, xm_bubble, md_busy, md_error};

  localparam logic [9:0] E_RUN   = 10'b11111_000_00;
  localparam logic [9:0] E_LU    = 10'b00111_010_00;
  localparam logic [9:0] E_BR    = 10'b11111_110_00;
  localparam logic [9:0] E_MDGO  = 10'b00011_001_00;
  localparam logic [9:0] E_WAIT  = 10'b00011_001_10;
  localparam logic [9:0] E_RDY   = 10'b11111_000_10;
  localparam logic [9:0] E_ERR   = 10'b00000_000_01;
  localparam logic [9:0] E_ZERO  = 10'b00000_000_00;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  task automatic check10(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s outputs got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s stall_count got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Entered at posedge+1: drive inputs, compare at negedge, return at next posedge+1.
  task automatic step(input string name, input logic [31:0] f, input logic [31:0] d,
                      input logic b, input logic r, input logic [9:0] exp);
    fd_ins       = f;
    dx_ins       = d;
    branch_taken = b;
    md_ready     = r;
    @(negedge clock);
    check10(name, outs, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    fd_ins = 32'h0; dx_ins = 32'h0; branch_taken = 1'b0; md_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_RUN = 0, M_WAIT = 1, M_ERR = 2;
  int          m_mode;
  int          m_waited;
  int unsigned m_stalls;

  function automatic bit m_reads(input logic [31:0] ins, input int r);
    int q[$];
    int op;
    op = int'(ins[31:27]);
    q.push_back(int'(ins[21:17]));
    if (op == 0) q.push_back(int'(ins[16:12]));
    if (op == 7 || op == 2 || op == 6) q.push_back(int'(ins[26:22]));
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_load_use(input logic [31:0] f, input logic [31:0] d);
    int rd;
    rd = int'(d[26:22]);
    return (int'(d[31:27]) == 8) && (rd != 0) && m_reads(f, rd);
  endfunction

  function automatic bit m_is_md(input logic [31:0] d);
    return (d[31:27] == 5'd0) && (int'(d[6:2]) == 6 || int'(d[6:2]) == 7);
  endfunction

  function automatic logic [9:0] m_out(input logic [31:0] f, input logic [31:0] d,
                                       input logic b, input logic r);
    if (m_mode == M_ERR) return E_ERR;
    if (m_mode == M_WAIT) return r ? E_RDY : E_WAIT;
    if (b) return E_BR;
    if (m_load_use(f, d)) return E_LU;
    if (m_is_md(d)) return E_MDGO;
    return E_RUN;
  endfunction

  task automatic m_advance(input logic [31:0] f, input logic [31:0] d,
                           input logic b, input logic r, input logic [9:0] e);
    if (e[9] == 1'b0) m_stalls++;
    if (m_mode == M_RUN) begin
      if (!b && !m_load_use(f, d) && m_is_md(d)) begin
        m_mode   = M_WAIT;
        m_waited = 0;
      end
    end else if (m_mode == M_WAIT) begin
      if (r) m_mode = M_RUN;
      else begin
        m_waited++;
        if (m_waited == 40) m_mode = M_ERR;
      end
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0] rd, rs, rt;
    rd = 5'($urandom_range(0, 3));
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0: return mk(5'b00000, rd, rs, rt, 5'($urandom_range(0, 7)));
      1: return mk(5'b01000, rd, rs, rt, 5'b00000);
      2: return mk(5'b00111, rd, rs, rt, 5'b00000);
      3: return mk(5'b00010, rd, rs, rt, 5'b00000);
      4: return mk(5'b00110, rd, rs, rt, 5'b00000);
      5: return mk(5'b00101, rd, rs, rt, 5'b00000);
      6: return mk(5'b00000, rd, rs, rt, 5'b00110);
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic        br;
    logic [9:0]  exp;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] lw5, add_rs5, mul_i, nop_i;
  int unsigned exp_stall;

  initial begin
    lw5     = mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'b00000);
    add_rs5 = mk(5'b00000, 5'd6, 5'd5, 5'd7, 5'b00000);
    mul_i   = mk(5'b00000, 5'd9, 5'd1, 5'd2, 5'b00110);
    nop_i   = 32'h0;

    tbl.push_back('{nop_i, nop_i, 1'b0, E_RUN});
    tbl.push_back('{add_rs5, lw5, 1'b0, E_LU});
    tbl.push_back('{mk(5'b00000, 5'd6, 5'd7, 5'd5, 5'b00000), lw5, 1'b0, E_LU});
    tbl.push_back('{mk(5'b00000, 5'd6, 5'd0, 5'd7, 5'b00000),
                    mk(5'b01000, 5'd0, 5'd1, 5'd0, 5'b00000), 1'b0, E_RUN});
    tbl.push_back('{mk(5'b00101, 5'd6, 5'd7, 5'd5, 5'b00000), lw5, 1'b0, E_RUN});
    tbl.push_back('{mk(5'b00111, 5'd5, 5'd7, 5'd0, 5'b00000), lw5, 1'b0, E_LU});
    tbl.push_back('{mk(5'b00010, 5'd5, 5'd7, 5'd0, 5'b00000), lw5, 1'b0, E_LU});
    tbl.push_back('{mk(5'b00110, 5'd5, 5'd7, 5'd0, 5'b00000), lw5, 1'b0, E_LU});
    tbl.push_back('{mk(5'b00101, 5'd5, 5'd7, 5'd0, 5'b00000), lw5, 1'b0, E_RUN});
    tbl.push_back('{mk(5'b01000, 5'd6, 5'd5, 5'd0, 5'b00000), lw5, 1'b0, E_LU});
    tbl.push_back('{add_rs5, mk(5'b00000, 5'd5, 5'd1, 5'd2, 5'b00000), 1'b0, E_RUN});
    tbl.push_back('{add_rs5, lw5, 1'b1, E_BR});
    tbl.push_back('{nop_i, nop_i, 1'b1, E_BR});
    tbl.push_back('{nop_i, mul_i, 1'b1, E_BR});

    // Reset hold: every output low.
    fd_ins = add_rs5; dx_ins = lw5; branch_taken = 1'b1; md_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check10("reset_hold", outs, E_ZERO);
    check32("reset_hold", stall_count, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Table-driven single-cycle vectors (FSM stays in RUN throughout).
    exp_stall = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].fd, tbl[i].dx, tbl[i].br, 1'b0, tbl[i].exp);
      if (tbl[i].exp[9] == 1'b0) exp_stall++;
    end
`ifdef PIPE_STALL_COUNT_EN
    check32("table_stalls", stall_count, exp_stall);
`else
    check32("table_stalls", stall_count, 32'd0);
`endif

    // Load-use then mult/div with ready after 16 wait cycles.
    do_reset();
    step("lu_stall", add_rs5, lw5, 1'b0, 1'b0, E_LU);
    step("lu_clear", add_rs5, nop_i, 1'b0, 1'b0, E_RUN);
    step("md_start", nop_i, mul_i, 1'b0, 1'b0, E_MDGO);
    for (int k = 0; k < 16; k++)
      step($sformatf("md_wait%0d", k), nop_i, mul_i, (k == 3) ? 1'b1 : 1'b0, 1'b0, E_WAIT);
    step("md_ready", nop_i, mul_i, 1'b0, 1'b1, E_RDY);
    step("md_back_run", nop_i, nop_i, 1'b0, 1'b0, E_RUN);
`ifdef PIPE_STALL_COUNT_EN
    check32("stall_18", stall_count, 32'd18);
`else
    check32("stall_18", stall_count, 32'd0);
`endif

    // Timeout: 40 busy cycles, then sticky error ignoring ready/branch.
    do_reset();
    step("to_start", nop_i, mul_i, 1'b0, 1'b0, E_MDGO);
    for (int k = 0; k < 40; k++)
      step($sformatf("to_wait%0d", k), nop_i, mul_i, 1'b0, 1'b0, E_WAIT);
    for (int k = 0; k < 3; k++)
      step($sformatf("to_err%0d", k), nop_i, mul_i, 1'b1, 1'b1, E_ERR);

    // Reset asserted mid-MD_WAIT: outputs drop at once, RUN after release.
    do_reset();
    step("rst_md_start", nop_i, mul_i, 1'b0, 1'b0, E_MDGO);
    for (int k = 0; k < 5; k++)
      step($sformatf("rst_md_wait%0d", k), nop_i, mul_i, 1'b0, 1'b0, E_WAIT);
    reset_n = 1'b0;
    #1;
    check10("rst_immediate", outs, E_ZERO);
    check32("rst_immediate", stall_count, 32'd0);
    fd_ins = nop_i; dx_ins = nop_i;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step("rst_release", nop_i, nop_i, 1'b0, 1'b0, E_RUN);

    // Randomized run against the reference model.
    do_reset();
    m_mode = M_RUN; m_waited = 0; m_stalls = 0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] f, d;
      logic        b, r;
      logic [9:0]  e;
      f = rand_ins();
      d = rand_ins();
      b = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 3) == 0);
      e = m_out(f, d, b, r);
      step($sformatf("rand%0d", c), f, d, b, r, e);
      m_advance(f, d, b, r, e);
    end
`ifdef PIPE_STALL_COUNT_EN
    check32("rand_stalls", stall_count, m_stalls);
`else
    check32("rand_stalls", stall_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
